// File: rtl/dmem_arb_pkg.sv
// Shared constants and types for the two-port DMEM arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    PORT_CORE = 1'b0,
    PORT_DMA  = 1'b1
  } port_id_e;

  localparam int DEFAULT_DEPTH_WORDS = 128;
  localparam int DEFAULT_MAX_WAIT    = 4;

  // Counter width able to hold 0..max_wait; never narrower than one bit.
  function automatic int cnt_width(input int max_wait);
    return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/dmem_arb_age_ctr.sv
// Saturating count of port-0 grants taken while the DMA port is waiting.
module dmem_arb_age_ctr
  import dmem_arb_pkg::*;
#(
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int            CW      = cnt_width(MAX_WAIT);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != MAX_CNT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign sat = (r_cnt == MAX_CNT);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (core / DMA) arbiter in front of a single-cycle DMEM.
// Define DMEM_ARB_ERR_EN to flag misaligned or out-of-range accesses.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int MAX_WAIT    = DEFAULT_MAX_WAIT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req_valid,
  output logic        p0_req_ready,
  input  logic        p0_req_we,
  input  logic [31:0] p0_req_addr,
  input  logic [31:0] p0_req_wdata,
  output logic        p0_rsp_valid,
  output logic [31:0] p0_rsp_rdata,
  output logic        p0_rsp_err,
  input  logic        p1_req_valid,
  output logic        p1_req_ready,
  input  logic        p1_req_we,
  input  logic [31:0] p1_req_addr,
  input  logic [31:0] p1_req_wdata,
  output logic        p1_rsp_valid,
  output logic [31:0] p1_rsp_rdata,
  output logic        p1_rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

`ifdef DMEM_ARB_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH_WORDS);

  logic        w_g0, w_g1, w_sat, w_err, w_we;
  port_id_e    w_sel;
  logic [31:0] w_addr, w_wdata, w_rsp_data;

  logic        r_vld0_p1, r_vld1_p1, r_err0_p1, r_err1_p1;
  logic [31:0] r_rdata0_p1, r_rdata1_p1;

  // Stage 0: arbitrate and drive the DMEM in the accept cycle.
  assign w_g1  = rst_n & p1_req_valid & (~p0_req_valid | w_sat);
  assign w_g0  = rst_n & p0_req_valid & ~w_g1;
  assign w_sel = w_g1 ? PORT_DMA : PORT_CORE;

  assign p0_req_ready = w_g0;
  assign p1_req_ready = w_g1;

  dmem_arb_age_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_age_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_g0 & p1_req_valid),
    .clr   (w_g1 | ~p1_req_valid),
    .sat   (w_sat)
  );

  always_comb begin
    w_addr  = '0;
    w_wdata = '0;
    w_we    = 1'b0;
    if (w_g0 || w_g1) begin
      if (w_sel == PORT_DMA) begin
        w_addr  = p1_req_addr;
        w_wdata = p1_req_wdata;
        w_we    = p1_req_we;
      end else begin
        w_addr  = p0_req_addr;
        w_wdata = p0_req_wdata;
        w_we    = p0_req_we;
      end
    end
  end

  assign w_err = ERR_EN && (w_g0 || w_g1) &&
                 ((w_addr[1:0] != 2'b00) || ({1'b0, w_addr} >= ADDR_LIMIT));

  assign mem_addr   = w_addr;
  assign mem_wdata  = w_wdata;
  assign mem_we     = w_we & ~w_err;
  assign w_rsp_data = (w_we || w_err) ? 32'h0 : mem_rdata;

  // Stage 1: one-cycle response back to the accepting port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld0_p1   <= 1'b0;
      r_vld1_p1   <= 1'b0;
      r_err0_p1   <= 1'b0;
      r_err1_p1   <= 1'b0;
      r_rdata0_p1 <= '0;
      r_rdata1_p1 <= '0;
    end else begin
      r_vld0_p1 <= w_g0;
      r_vld1_p1 <= w_g1;
      if (w_g0) begin
        r_rdata0_p1 <= w_rsp_data;
        r_err0_p1   <= w_err;
      end
      if (w_g1) begin
        r_rdata1_p1 <= w_rsp_data;
        r_err1_p1   <= w_err;
      end
    end
  end

  // Gating with rst_n drops a response whose cycle overlaps reset.
  assign p0_rsp_valid = r_vld0_p1 & rst_n;
  assign p1_rsp_valid = r_vld1_p1 & rst_n;
  assign p0_rsp_rdata = r_rdata0_p1;
  assign p1_rsp_rdata = r_rdata1_p1;
  assign p0_rsp_err   = ERR_EN ? r_err0_p1 : 1'b0;
  assign p1_rsp_err   = ERR_EN ? r_err1_p1 : 1'b0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed, table-driven bench for dmem_arbiter with a simple DMEM model.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_ERR_EN
  localparam bit EXP_ERR = 1'b1;
`else
  localparam bit EXP_ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req_valid, p0_req_ready, p0_req_we;
  logic [31:0] p0_req_addr, p0_req_wdata;
  logic        p0_rsp_valid, p0_rsp_err;
  logic [31:0] p0_rsp_rdata;
  logic        p1_req_valid, p1_req_ready, p1_req_we;
  logic [31:0] p1_req_addr, p1_req_wdata;
  logic        p1_rsp_valid, p1_rsp_err;
  logic [31:0] p1_rsp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  logic [31:0] dmem [0:127];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  assign mem_rdata = dmem[mem_addr[8:2]];
  always @(posedge clk) if (mem_we) dmem[mem_addr[8:2]] <= mem_wdata;

  dmem_arbiter #(.DEPTH_WORDS(128), .MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
    .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
    .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata), .p0_rsp_err(p0_rsp_err),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
    .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
    .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata), .p1_rsp_err(p1_rsp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        v0, we0;
    logic [31:0] a0, d0;
    logic        v1, we1;
    logic [31:0] a1, d1;
    logic        e_rdy0, e_rdy1, e_we;
    logic [31:0] e_addr, e_wdata;
    logic        e_rv0, e_rv1;
    logic [31:0] e_rd0, e_rd1;
  } vec_t;

  vec_t tbl [20];

  function automatic vec_t mk(
    input logic v0, input logic we0, input logic [31:0] a0, input logic [31:0] d0,
    input logic v1, input logic we1, input logic [31:0] a1, input logic [31:0] d1,
    input logic r0, input logic r1, input logic we, input logic [31:0] ad, input logic [31:0] wd,
    input logic rv0, input logic rv1, input logic [31:0] rd0, input logic [31:0] rd1);
    vec_t v;
    v.v0 = v0; v.we0 = we0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.we1 = we1; v.a1 = a1; v.d1 = d1;
    v.e_rdy0 = r0; v.e_rdy1 = r1; v.e_we = we; v.e_addr = ad; v.e_wdata = wd;
    v.e_rv0 = rv0; v.e_rv1 = rv1; v.e_rd0 = rd0; v.e_rd1 = rd1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input logic v0, input logic we0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic v1, input logic we1, input logic [31:0] a1, input logic [31:0] d1);
    p0_req_valid = v0; p0_req_we = we0; p0_req_addr = a0; p0_req_wdata = d0;
    p1_req_valid = v1; p1_req_we = we1; p1_req_addr = a1; p1_req_wdata = d1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] DB = 32'hDEADBEEF;

  initial begin
    for (int i = 0; i < 128; i++) dmem[i] = 32'h0;

    // Row n checks readies/DMEM for its own inputs and the response of row n-1.
    tbl[0]  = mk(0,0,0,0,          0,0,0,0,          0,0,0,0,0,          1,0,0,0);
    tbl[1]  = mk(0,0,0,0,          1,1,32'h10,DB,    0,1,1,32'h10,DB,    0,0,0,0);
    tbl[2]  = mk(0,0,0,0,          1,0,32'h10,0,     0,1,0,32'h10,0,     0,1,0,0);
    tbl[3]  = mk(0,0,0,0,          0,0,0,0,          0,0,0,0,0,          0,1,0,DB);
    tbl[4]  = mk(0,0,0,0,          0,0,0,0,          0,0,0,0,0,          0,0,0,DB);
    tbl[5]  = mk(1,1,32'h20,1,     1,1,32'h20,2,     1,0,1,32'h20,1,     0,0,0,DB);
    tbl[6]  = mk(0,0,0,0,          1,1,32'h20,2,     0,1,1,32'h20,2,     1,0,0,DB);
    tbl[7]  = mk(1,0,32'h20,0,     0,0,0,0,          1,0,0,32'h20,0,     0,1,0,0);
    tbl[8]  = mk(0,0,0,0,          0,0,0,0,          0,0,0,0,0,          1,0,2,0);
    tbl[9]  = mk(1,0,32'h10,0,     1,0,32'h20,0,     1,0,0,32'h10,0,     0,0,2,0);
    tbl[10] = mk(1,0,32'h10,0,     1,0,32'h20,0,     1,0,0,32'h10,0,     1,0,DB,0);
    tbl[11] = mk(1,0,32'h10,0,     1,0,32'h20,0,     1,0,0,32'h10,0,     1,0,DB,0);
    tbl[12] = mk(1,0,32'h10,0,     1,0,32'h20,0,     1,0,0,32'h10,0,     1,0,DB,0);
    tbl[13] = mk(1,0,32'h10,0,     1,0,32'h20,0,     0,1,0,32'h20,0,     1,0,DB,0);
    tbl[14] = mk(1,0,32'h10,0,     1,0,32'h20,0,     1,0,0,32'h10,0,     0,1,DB,2);
    tbl[15] = mk(1,0,32'h10,0,     1,0,32'h20,0,     1,0,0,32'h10,0,     1,0,DB,2);
    tbl[16] = mk(1,0,32'h10,0,     1,0,32'h20,0,     1,0,0,32'h10,0,     1,0,DB,2);
    tbl[17] = mk(1,0,32'h10,0,     1,0,32'h20,0,     1,0,0,32'h10,0,     1,0,DB,2);
    tbl[18] = mk(1,0,32'h10,0,     1,0,32'h20,0,     0,1,0,32'h20,0,     1,0,DB,2);
    tbl[19] = mk(0,0,0,0,          0,0,0,0,          0,0,0,0,0,          0,1,DB,2);

    // Reset held with both ports requesting.
    rst_n = 1'b0;
    drive(1,0,0,0, 1,0,0,0);
    next_cycle();
    @(negedge clk);
    chk("rst_rdy0", 32'(p0_req_ready), 32'(0));
    chk("rst_rdy1", 32'(p1_req_ready), 32'(0));
    chk("rst_mem_we", 32'(mem_we), 32'(0));
    chk("rst_rv0", 32'(p0_rsp_valid), 32'(0));
    chk("rst_rv1", 32'(p1_rsp_valid), 32'(0));
    chk("rst_rd0", p0_rsp_rdata, 32'h0);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_rdy0", 32'(p0_req_ready), 32'(1));
    chk("rel_rdy1", 32'(p1_req_ready), 32'(0));
    next_cycle();

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].v0, tbl[i].we0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].we1, tbl[i].a1, tbl[i].d1);
      @(negedge clk);
      chk($sformatf("r%0d_rdy0", i), 32'(p0_req_ready), 32'(tbl[i].e_rdy0));
      chk($sformatf("r%0d_rdy1", i), 32'(p1_req_ready), 32'(tbl[i].e_rdy1));
      chk($sformatf("r%0d_we", i), 32'(mem_we), 32'(tbl[i].e_we));
      chk($sformatf("r%0d_addr", i), mem_addr, tbl[i].e_addr);
      chk($sformatf("r%0d_wdata", i), mem_wdata, tbl[i].e_wdata);
      chk($sformatf("r%0d_rv0", i), 32'(p0_rsp_valid), 32'(tbl[i].e_rv0));
      chk($sformatf("r%0d_rv1", i), 32'(p1_rsp_valid), 32'(tbl[i].e_rv1));
      chk($sformatf("r%0d_rd0", i), p0_rsp_rdata, tbl[i].e_rd0);
      chk($sformatf("r%0d_rd1", i), p1_rsp_rdata, tbl[i].e_rd1);
      next_cycle();
    end

    // Reset asserted in the cycle after a read accept drops the response.
    drive(1,0,32'h10,0, 0,0,0,0);
    @(negedge clk);
    chk("mid_rdy0", 32'(p0_req_ready), 32'(1));
    next_cycle();
    rst_n = 1'b0;
    drive(0,0,0,0, 0,0,0,0);
    @(negedge clk);
    chk("mid_rv0_in_rst", 32'(p0_rsp_valid), 32'(0));
    chk("mid_rv1_in_rst", 32'(p1_rsp_valid), 32'(0));
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rv0_after", 32'(p0_rsp_valid), 32'(0));
    chk("mid_rv1_after", 32'(p1_rsp_valid), 32'(0));
    chk("mid_rd0_after", p0_rsp_rdata, 32'h0);
    next_cycle();

    // Address checking: misaligned, just past the end, last valid word.
    drive(1,1,32'h202,5, 0,0,0,0);
    @(negedge clk);
    chk("err_202_we", 32'(mem_we), 32'(!EXP_ERR));
    next_cycle();
    drive(1,1,32'h200,6, 0,0,0,0);
    @(negedge clk);
    chk("err_202_rv", 32'(p0_rsp_valid), 32'(1));
    chk("err_202_err", 32'(p0_rsp_err), 32'(EXP_ERR));
    chk("err_200_we", 32'(mem_we), 32'(!EXP_ERR));
    next_cycle();
    drive(1,1,32'h1FC,7, 0,0,0,0);
    @(negedge clk);
    chk("err_200_err", 32'(p0_rsp_err), 32'(EXP_ERR));
    chk("err_1fc_we", 32'(mem_we), 32'(1));
    next_cycle();
    drive(0,0,0,0, 0,0,0,0);
    @(negedge clk);
    chk("err_1fc_rv", 32'(p0_rsp_valid), 32'(1));
    chk("err_1fc_err", 32'(p0_rsp_err), 32'(0));
    chk("err_1fc_rd", p0_rsp_rdata, 32'h0);
    chk("err_p1_err", 32'(p1_rsp_err), 32'(0));
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 128: number of 32-bit words in the attached DMEM.
REQ-002 SHALL have parameter MAX_WAIT, default 4: consecutive port-0 grants tolerated while port 1 waits.
REQ-003 SHALL have one clock and a synchronous, active-low reset: clk (input, 1) and rst_n (input, 1).
REQ-004 Per port i in {0 = core, 1 = DMA}, SHALL have: pI_req_valid in 1; pI_req_ready out 1; pI_req_we in 1; pI_req_addr in 32 (byte address); pI_req_wdata in 32.
REQ-005 Per port i, SHALL have: pI_rsp_valid out 1; pI_rsp_rdata out 32; pI_rsp_err out 1.
REQ-006 SHALL have DMEM-side ports: mem_addr out 32; mem_wdata out 32; mem_we out 1 (drives MemRW); mem_rdata in 32 (combinational read, same cycle).

Function
REQ-007 Request handshake SHALL be: a request is accepted in the cycle where pI_req_valid and pI_req_ready are both 1; at most one port is accepted per cycle.
REQ-008 pI_req_ready SHALL be combinational, equal to that port's grant; a port with valid=0 is never granted.
REQ-009 Arbitration SHALL be fixed priority to port 0, except port 1 wins when wait_cnt == MAX_WAIT.
REQ-010 wait_cnt (width clog2(MAX_WAIT+1)) SHALL increment when port 0 is granted while p1_req_valid=1, clear when port 1 is granted or p1_req_valid=0, and saturate at MAX_WAIT.
REQ-011 On accept, mem_addr, mem_wdata and mem_we SHALL carry the granted request in the same cycle; with no grant, mem_we=0 and mem_addr/mem_wdata hold 0.
REQ-012 Responses SHALL arrive one cycle after accept on the accepting port only: pI_rsp_valid=1 for exactly one cycle, for both reads and writes.
REQ-013 Read data SHALL be registered: pI_rsp_rdata = mem_rdata sampled in the accept cycle; writes return rdata 0.
REQ-014 pI_rsp_rdata SHALL hold its value while rsp_valid=0; responses SHALL NOT be back-pressured.
REQ-015 Back-to-back accepts (one per cycle, any port mix) SHALL be supported with no bubble.
REQ-016 Simultaneous valids: port 0 wins unless REQ-009 applies; the loser's ready stays 0 and it must hold its request stable.

Reset
REQ-017 While rst_n=0 at a clk edge, SHALL clear wait_cnt, all rsp_valid, rsp_rdata and rsp_err to 0; mem_we SHALL be 0 combinationally while rst_n=0 and req_ready SHALL be 0.
REQ-018 A response pending when reset asserts SHALL be dropped and never presented.

Configuration
REQ-019 With DMEM_ARB_ERR_EN defined, an accepted request with addr[1:0]!=0 or addr >= 4*DEPTH_WORDS SHALL be flagged: mem_we forced 0, next-cycle rsp_err=1 and rsp_rdata=0.
REQ-020 Without DMEM_ARB_ERR_EN, rsp_err SHALL be tied 0 and addresses pass through unchecked (DMEM wraps them by word index).

Structure
REQ-021 Package dmem_arb_pkg SHALL hold the port-ID constants (PORT_CORE=0, PORT_DMA=1) and the default DEPTH_WORDS and MAX_WAIT values.
REQ-022 The starvation counter SHALL be a sub-module dmem_arb_age_ctr (inputs inc, clr; output sat); all other logic is flat.

Verification
REQ-023 Reset: hold rst_n=0 with both valids=1 -> readies 0, mem_we 0, rsp_valid 0; after release, first cycle grants port 0.
REQ-024 Read/write: p1 writes 0xDEADBEEF to 0x10, then p1 reads 0x10 -> mem_we=1 in cycle 0; read rsp_valid one cycle after accept with rdata 0xDEADBEEF.
REQ-025 Starvation: both ports valid continuously, MAX_WAIT=4 -> grant pattern 0,0,0,0,1 repeating.
REQ-026 Contention: p0 writes 0x1 and p1 writes 0x2 to 0x20 in the same cycle -> p0 accepted first, p1 the next cycle; read of 0x20 returns 0x2.
REQ-027 Errors, with DMEM_ARB_ERR_EN: p0 write to 0x202 -> mem_we 0, rsp_err 1; p0 write to 0x200 -> rsp_err 1; p0 write to 0x1FC -> rsp_err 0. Without the macro: rsp_err always 0.
REQ-028 Reset mid-operation: assert rst_n=0 in the cycle after a read accept -> no rsp_valid is seen on either port.
